// File: rtl/ap_addsub_pipe.sv
// ap_addsub_pipe: pipelined two's-complement adder/subtractor with valid/ready
// handshake, unsigned carry/borrow and signed overflow flags.
// Optional signed saturation is compiled in when AP_ADDSUB_SAT_EN is defined.
// For STAGES > 1 the add is split into lower/upper halves across the first two
// stages with a registered inter-half carry; further stages only delay.
module ap_addsub_pipe #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             op_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] c_out,
  output logic             carry_out,
  output logic             ovf_out,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int unsigned LO = WIDTH / 2;
  localparam int unsigned HI = WIDTH - LO;

  typedef struct packed {
    logic [WIDTH-1:0] c;
    logic             cy;
    logic             ov;
  } res_t;

  logic             adv;
  logic             xfer;
  logic [WIDTH-1:0] b_eff;
  logic [LO:0]      lo_sum;
  res_t             out_q;
  logic             out_v_q;

  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;
  assign xfer      = in_valid && adv;
  assign c_out     = out_q.c;
  assign carry_out = out_q.cy;
  assign ovf_out   = out_q.ov;
  assign out_valid = out_v_q;

  // Subtraction as A + ~B + 1: invert B and inject op as the low carry-in.
  always_comb begin
    b_eff  = op_in ? ~b_in : b_in;
    lo_sum = {1'b0, a_in[LO-1:0]} + {1'b0, b_eff[LO-1:0]} + {{LO{1'b0}}, op_in};
  end

  // Upper-half add plus flag derivation (and optional saturation).
  function automatic res_t upper(input logic [HI-1:0] ah, input logic [HI-1:0] bh,
                                 input logic cin, input logic [LO-1:0] lo,
                                 input logic op);
    logic [HI:0] hs;
    res_t        r;
    hs   = {1'b0, ah} + {1'b0, bh} + {{HI{1'b0}}, cin};
    r.c  = {hs[HI-1:0], lo};
    // Carry for add; borrow (inverted carry) for subtract.
    r.cy = hs[HI] ^ op;
    r.ov = (ah[HI-1] == bh[HI-1]) && (r.c[WIDTH-1] != ah[HI-1]);
`ifdef AP_ADDSUB_SAT_EN
    if (r.ov)
      r.c = r.c[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
`endif
    return r;
  endfunction

  generate
    if (STAGES == 1) begin : g_single
      // Single stage: full computation registered straight into the output.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          out_v_q <= 1'b0;
          out_q   <= '0;
        end else if (adv) begin
          out_v_q <= xfer;
          if (xfer)
            out_q <= upper(a_in[WIDTH-1:LO], b_eff[WIDTH-1:LO], lo_sum[LO],
                           lo_sum[LO-1:0], op_in);
        end
      end
    end else begin : g_multi
      logic          s0_v;
      logic [LO-1:0] s0_lo;
      logic          s0_c;
      logic [HI-1:0] s0_ah;
      logic [HI-1:0] s0_bh;
      logic          s0_op;
      res_t          d  [1:STAGES-1];
      logic          dv [1:STAGES-1];

      // Stage 0: lower-half sum, its carry, and the upper operand halves.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          s0_v  <= 1'b0;
          s0_lo <= '0;
          s0_c  <= 1'b0;
          s0_ah <= '0;
          s0_bh <= '0;
          s0_op <= 1'b0;
        end else if (adv) begin
          s0_v <= xfer;
          if (xfer) begin
            s0_lo <= lo_sum[LO-1:0];
            s0_c  <= lo_sum[LO];
            s0_ah <= a_in[WIDTH-1:LO];
            s0_bh <= b_eff[WIDTH-1:LO];
            s0_op <= op_in;
          end
        end
      end

      // Stage 1 completes the upper half; later stages are a plain delay line.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int unsigned k = 1; k < STAGES; k++) begin
            dv[k] <= 1'b0;
            d[k]  <= '0;
          end
        end else if (adv) begin
          dv[1] <= s0_v;
          if (s0_v)
            d[1] <= upper(s0_ah, s0_bh, s0_c, s0_lo, s0_op);
          for (int unsigned k = 2; k < STAGES; k++) begin
            dv[k] <= dv[k-1];
            d[k]  <= d[k-1];
          end
        end
      end

      assign out_q   = d[STAGES-1];
      assign out_v_q = dv[STAGES-1];
    end
  endgenerate

endmodule
